// File: rtl/pm_line_fill_server.sv
// Instruction-cache line-fill responder: reads one 8-word line from the synchronous program ROM and streams it into the cache.
// Optional build macro CRITICAL_WORD_FIRST_EN: start at the missed word and add the crit_valid_o output.
module pm_line_fill_server #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fill_req_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] rom_address_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              cache_wren_o,
  output logic [1:0]        cache_wrline_o,
  output logic [2:0]        cache_wroffset_o,
  output logic [DATA_W-1:0] cache_wrdata_o,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic              crit_valid_o,
`endif
  output logic [ADDR_W-6:0] cache_wrtag_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic CWF = 1'b1;
`else
  localparam logic CWF = 1'b0;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   rom_address_q;
  logic [3:0]          iss_cnt_q, wr_cnt_q;
  logic                addr_vld_q, busy_q, done_q;
  logic [1:0]          line_q;
  logic [ADDR_W-6:0]   tag_q;
  logic [ROM_LAT-1:0]       pv_q;
  logic [ROM_LAT-1:0][2:0]  po_q;
  logic [2:0]          start_d, iss_off_d;
  logic                wren;

  assign start_d   = fill_addr_i[2:0] & {3{CWF}};
  // Offset increments wrap inside the line, so line/tag bits never change.
  assign iss_off_d = rom_address_q[2:0] + 3'd1;
  assign wren      = pv_q[ROM_LAT-1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      rom_address_q <= '0;
      iss_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      addr_vld_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      line_q        <= '0;
      tag_q         <= '0;
    end else begin
      // Raise done one edge early so the pulse lands on the 8th write.
      done_q <= wren && (wr_cnt_q == 4'd6);
      if (wren) wr_cnt_q <= wr_cnt_q + 4'd1;
      case (state_q)
        IDLE: if (fill_req_i) begin
          rom_address_q <= {fill_addr_i[ADDR_W-1:3], start_d};
          line_q        <= fill_addr_i[4:3];
          tag_q         <= fill_addr_i[ADDR_W-1:5];
          iss_cnt_q     <= 4'd1;
          wr_cnt_q      <= '0;
          addr_vld_q    <= 1'b1;
          busy_q        <= 1'b1;
          state_q       <= ISSUE;
        end
        ISSUE: begin
          if (iss_cnt_q == 4'd8) begin
            addr_vld_q <= 1'b0;
            state_q    <= DRAIN;
          end else begin
            rom_address_q[2:0] <= iss_off_d;
            iss_cnt_q          <= iss_cnt_q + 4'd1;
          end
        end
        DRAIN: if (done_q) begin
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // (valid, offset) travels alongside the ROM so writes line up with returned data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pv_q <= '0;
      po_q <= '0;
    end else begin
      pv_q[0] <= addr_vld_q;
      po_q[0] <= rom_address_q[2:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [2:0] start_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) start_q <= '0;
    else if (state_q == IDLE && fill_req_i) start_q <= start_d;
  end
  assign crit_valid_o = wren && (po_q[ROM_LAT-1] == start_q);
`endif

  assign fill_busy_o      = busy_q;
  assign fill_done_o      = done_q;
  assign rom_address_o    = rom_address_q;
  assign cache_wren_o     = wren;
  assign cache_wroffset_o = wren ? po_q[ROM_LAT-1] : 3'd0;
  assign cache_wrdata_o   = wren ? rom_data_i : '0;
  assign cache_wrline_o   = line_q;
  assign cache_wrtag_o    = tag_q;

endmodule
